// File: rtl/sinusoid_phase_gen_if.sv
// Sample stream from sinusoid_phase_gen to the Sinusoid stage.
// The producer holds a reduced angle x and a neg flag while out_valid is high.
interface sinusoid_phase_gen_if #(
    parameter int unsigned PHASE_W = 16
) ();
    logic               out_valid;
    logic               out_ready;
    logic [PHASE_W-1:0] x;
    logic               neg;

    modport master (output out_valid, output x, output neg, input out_ready);
    modport slave  (input out_valid, input x, input neg, output out_ready);
endinterface

// File: rtl/sinusoid_phase_gen.sv
// Q8.8 phase accumulator, modulo 2*PI, range-reduced to [0, PI) with a neg flag.
// Optional burst counter and done pulse are enabled with `define BURST_COUNT_EN.
module sinusoid_phase_gen #(
    parameter int unsigned       PHASE_W = 16,
    parameter logic [PHASE_W-1:0] PI_Q   = 16'h0324
`ifdef BURST_COUNT_EN
    ,
    parameter int unsigned       CNT_W   = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] step,
    input  logic [PHASE_W-1:0] init_phase,
    output logic               busy,
    output logic               err,
`ifdef BURST_COUNT_EN
    input  logic [CNT_W-1:0]   burst_len,
    output logic               done,
`endif
    sinusoid_phase_gen_if.master smp
);

    localparam logic [PHASE_W:0] TWO_PI = {PI_Q, 1'b0};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] step_q;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] phase_nxt;
    logic               xfer;
    logic               bad_start;
`ifdef BURST_COUNT_EN
    logic [CNT_W-1:0]   cnt_q;
`endif

    // {neg, x} for a phase already in [0, TWO_PI)
    function automatic logic [PHASE_W:0] reduce(input logic [PHASE_W-1:0] p);
        if (p < PI_Q) return {1'b0, p};
        else          return {1'b1, PHASE_W'(p - PI_Q)};
    endfunction

    // Wide sum so step + phase near 2*PI never overflows before the wrap
    always_comb begin
        sum       = {1'b0, phase_q} + {1'b0, step_q};
        phase_nxt = (sum >= TWO_PI) ? PHASE_W'(sum - TWO_PI) : PHASE_W'(sum);
        xfer      = smp.out_valid && smp.out_ready;
        bad_start = ({1'b0, step} >= TWO_PI) || ({1'b0, init_phase} >= TWO_PI);
`ifdef BURST_COUNT_EN
        bad_start = bad_start || (burst_len == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            step_q        <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
            smp.out_valid <= 1'b0;
            smp.x         <= '0;
            smp.neg       <= 1'b0;
`ifdef BURST_COUNT_EN
            cnt_q         <= '0;
            done          <= 1'b0;
`endif
        end else begin
`ifdef BURST_COUNT_EN
            done <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // stop in the same cycle suppresses start entirely, err included
                    if (start && !stop) begin
                        if (bad_start) begin
                            err <= 1'b1;
                        end else begin
                            err                 <= 1'b0;
                            phase_q             <= init_phase;
                            step_q              <= step;
                            {smp.neg, smp.x}    <= reduce(init_phase);
                            smp.out_valid       <= 1'b1;
                            busy                <= 1'b1;
                            state_q             <= RUN;
`ifdef BURST_COUNT_EN
                            cnt_q               <= burst_len;
`endif
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        smp.out_valid <= 1'b0;
                        busy          <= 1'b0;
                        state_q       <= IDLE;
                    end else if (xfer) begin
                        phase_q          <= phase_nxt;
                        {smp.neg, smp.x} <= reduce(phase_nxt);
`ifdef BURST_COUNT_EN
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            smp.out_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state_q       <= IDLE;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sinusoid_phase_gen.sv
// Directed bench for sinusoid_phase_gen with hand-computed expected samples.
module tb_sinusoid_phase_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] step;
    logic [15:0] init_phase;
    logic        busy;
    logic        err;
`ifdef BURST_COUNT_EN
    logic [15:0] burst_len;
    logic        done;
`endif

    int errors = 0;
    int checks = 0;

    sinusoid_phase_gen_if #(.PHASE_W(16)) sif ();

    sinusoid_phase_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .init_phase (init_phase),
        .busy       (busy),
        .err        (err),
`ifdef BURST_COUNT_EN
        .burst_len  (burst_len),
        .done       (done),
`endif
        .smp        (sif.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_sample(input string tag, input logic [15:0] ex, input logic en);
        chk({tag, ".x"}, sif.x, ex);
        chk({tag, ".neg"}, 16'(sif.neg), 16'(en));
        chk({tag, ".valid"}, 16'(sif.out_valid), 16'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; step = '0; init_phase = '0;
        sif.out_ready = 1'b1;
`ifdef BURST_COUNT_EN
        burst_len = 16'hFFFF;
`endif
        tick();
        chk("rst.valid", 16'(sif.out_valid), 16'd0);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.err", 16'(err), 16'd0);
        chk("rst.x", sif.x, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Free run, step 1.0 rad, crossing PI and then 2*PI
        step = 16'h0100; init_phase = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("run.busy", 16'(busy), 16'd1);
        chk_sample("run0", 16'h0000, 1'b0);
        tick(); chk_sample("run1", 16'h0100, 1'b0);
        tick(); chk_sample("run2", 16'h0200, 1'b0);
        tick(); chk_sample("run3", 16'h0300, 1'b0);
        tick(); chk_sample("run4", 16'h00DC, 1'b1);
        tick(); chk_sample("run5", 16'h01DC, 1'b1);
        tick(); chk_sample("run6", 16'h02DC, 1'b1);
        tick(); chk_sample("wrap", 16'h00B8, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop.valid", 16'(sif.out_valid), 16'd0);
        chk("stop.busy", 16'(busy), 16'd0);
        tick();

        // Backpressure holds the sample, then resumes without skipping
        step = 16'h0100; init_phase = 16'h0200; sif.out_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_sample("bp.hold", 16'h0200, 1'b0);
            tick();
        end
        chk_sample("bp.hold", 16'h0200, 1'b0);
        sif.out_ready = 1'b1;
        tick();
        chk_sample("bp.resume", 16'h0300, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Wrap from the last legal phase, then asynchronous reset mid-run
        step = 16'h0001; init_phase = 16'h0647; start = 1'b1;
        tick();
        start = 1'b0;
        chk_sample("edge0", 16'h0323, 1'b1);
        tick();
        chk_sample("edge1", 16'h0000, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 16'(sif.out_valid), 16'd0);
        chk("arst.busy", 16'(busy), 16'd0);
        chk("arst.x", sif.x, 16'h0000);
        chk("arst.neg", 16'(sif.neg), 16'd0);
        chk("arst.err", 16'(err), 16'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Illegal step rejected, legal start clears err; step=0 holds x
        step = 16'h0648; init_phase = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad.err", 16'(err), 16'd1);
        chk("bad.busy", 16'(busy), 16'd0);
        chk("bad.valid", 16'(sif.out_valid), 16'd0);
        step = 16'h0000; init_phase = 16'h0100; start = 1'b1;
        tick();
        start = 1'b0;
        chk("good.err", 16'(err), 16'd0);
        chk("good.busy", 16'(busy), 16'd1);
        chk_sample("zero0", 16'h0100, 1'b0);
        tick(); chk_sample("zero1", 16'h0100, 1'b0);
        step = 16'h0100; init_phase = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        chk_sample("restart.ignored", 16'h0100, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // start+stop together: stop wins, illegal operands do not touch err
        step = 16'h0648; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("ss.busy", 16'(busy), 16'd0);
        chk("ss.err", 16'(err), 16'd0);
        chk("ss.valid", 16'(sif.out_valid), 16'd0);

`ifdef BURST_COUNT_EN
        // Burst of three samples, then done for one cycle
        step = 16'h0100; init_phase = 16'h0000; burst_len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk_sample("b0", 16'h0000, 1'b0);
        chk("b0.done", 16'(done), 16'd0);
        tick(); chk_sample("b1", 16'h0100, 1'b0);
        tick(); chk_sample("b2", 16'h0200, 1'b0);
        tick();
        chk("b.done", 16'(done), 16'd1);
        chk("b.valid", 16'(sif.out_valid), 16'd0);
        chk("b.busy", 16'(busy), 16'd0);
        tick();
        chk("b.done_clr", 16'(done), 16'd0);
        burst_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b0len.err", 16'(err), 16'd1);
        chk("b0len.busy", 16'(busy), 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
